// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for a 32-bit MIPS-style datapath with a memory-ready timeout.
// Optional performance counters (CycleCnt/InstrCnt) are enabled by defining MULTICYCLE_PERF_CNT_EN.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       shl_sel,
    output logic       shr_sel,
    output logic       Illegal,
    output logic       TimeoutErr,
    output logic [3:0] State
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstrCnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              at_limit_s;
    logic              timeout_s;
    logic              illegal_s;
    logic              complete_s;
    logic              mem_wait_s;
    logic              illegal_r;
    logic              timeout_r;
    logic              shift_r;
    logic [3:0]        rtype_op_s;
    logic              rtype_ok_s;
    logic              shift_s;

    logic       pc_write_s;
    logic [1:0] pc_src_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [3:0] alu_op_s;
    logic       shl_sel_s;
    logic       shr_sel_s;

    assign at_limit_s = (wait_cnt_r == WAIT_LAST);

    // R-type funct decode to ALU operation and shift-path selects
    always_comb begin
        rtype_op_s = ALU_ADD;
        rtype_ok_s = 1'b1;
        shift_s    = 1'b0;
        case (Funct)
            6'b100000: rtype_op_s = ALU_ADD;
            6'b100010: rtype_op_s = ALU_SUB;
            6'b100100: rtype_op_s = ALU_AND;
            6'b100101: rtype_op_s = ALU_OR;
            6'b101010: rtype_op_s = ALU_SLT;
            6'b000000: begin
                rtype_op_s = ALU_SLL;
                shift_s    = 1'b1;
            end
            6'b000010: begin
                rtype_op_s = ALU_SRL;
                shift_s    = 1'b1;
            end
            default: rtype_ok_s = 1'b0;
        endcase
    end

    // Next-state logic with abort, timeout and completion detection
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        illegal_s   = 1'b0;
        complete_s  = 1'b0;
        mem_wait_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_wait_s = 1'b1;
                if (MemReady) begin
                    state_nxt_s = S_DECODE;
                end else if (at_limit_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_nxt_s = S_MEMADR;
                    OP_RTYPE:     state_nxt_s = S_RTYPE_EX;
                    OP_BEQ:       state_nxt_s = S_BEQ;
                    OP_ADDI:      state_nxt_s = S_ADDI_EX;
                    OP_J:         state_nxt_s = S_JUMP;
                    default: begin
                        illegal_s   = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_nxt_s = S_MEMRD;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                mem_wait_s = 1'b1;
                if (MemReady) begin
                    state_nxt_s = S_MEMWB;
                end else if (at_limit_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                complete_s  = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_MEMWR: begin
                mem_wait_s = 1'b1;
                if (MemReady) begin
                    complete_s  = 1'b1;
                    state_nxt_s = S_FETCH;
                end else if (at_limit_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_RTYPE_EX: begin
                if (rtype_ok_s) begin
                    state_nxt_s = S_RTYPE_WB;
                end else begin
                    illegal_s   = 1'b1;
                    state_nxt_s = S_FETCH;
                end
            end
            S_RTYPE_WB, S_BEQ, S_ADDI_WB, S_JUMP: begin
                complete_s  = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_ADDI_EX: state_nxt_s = S_ADDI_WB;
            default:   state_nxt_s = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Memory wait counter: restarts on every state change and on a fetch retry
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt_r <= '0;
        end else if ((state_nxt_s != state_r) || timeout_s) begin
            wait_cnt_r <= '0;
        end else if (mem_wait_s && !MemReady) begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Error pulses, and shift selects carried from execute into writeback
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
            shift_r   <= 1'b0;
        end else begin
            illegal_r <= illegal_s;
            timeout_r <= timeout_s;
            if (state_r == S_RTYPE_EX) begin
                shift_r <= shift_s;
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Moore control decode; only fetch and beq look at inputs
    always_comb begin
        pc_write_s   = 1'b0;
        pc_src_s     = 2'b00;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_op_s     = ALU_ADD;
        shl_sel_s    = 1'b0;
        shr_sel_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                pc_write_s  = MemReady;
                ir_write_s  = MemReady;
            end
            S_DECODE: alu_src_b_s = 2'b11;
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = rtype_op_s;
                shl_sel_s   = shift_s;
                shr_sel_s   = shift_s;
            end
            S_RTYPE_WB: begin
                reg_dst_s   = 1'b1;
                reg_write_s = 1'b1;
                shl_sel_s   = shift_r;
                shr_sel_s   = shift_r;
            end
            S_BEQ: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALU_SUB;
                pc_src_s    = 2'b01;
                pc_write_s  = Zero;
            end
            S_ADDI_EX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_ADDI_WB: reg_write_s = 1'b1;
            S_JUMP: begin
                pc_src_s   = 2'b10;
                pc_write_s = 1'b1;
            end
            default: pc_write_s = 1'b0;
        endcase
    end

    // Outputs are forced low while reset is held so no write leaks during an abort
    always_comb begin
        PCWrite    = Reset & pc_write_s;
        PCSrc      = Reset ? pc_src_s : 2'b00;
        IorD       = Reset & iord_s;
        MemRead    = Reset & mem_read_s;
        MemWrite   = Reset & mem_write_s;
        IRWrite    = Reset & ir_write_s;
        RegDst     = Reset & reg_dst_s;
        MemtoReg   = Reset & mem_to_reg_s;
        RegWrite   = Reset & reg_write_s;
        ALUSrcA    = Reset & alu_src_a_s;
        ALUSrcB    = Reset ? alu_src_b_s : 2'b00;
        ALUOp      = Reset ? alu_op_s : 4'b0000;
        shl_sel    = Reset & shl_sel_s;
        shr_sel    = Reset & shr_sel_s;
        Illegal    = Reset & illegal_r;
        TimeoutErr = Reset & timeout_r;
    end

    assign State = state_r;

`ifdef MULTICYCLE_PERF_CNT_EN
    // Performance counters; aborted instructions never reach a completing state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            CycleCnt <= '0;
            InstrCnt <= '0;
        end else begin
            CycleCnt <= CycleCnt + 1'b1;
            if (complete_s) begin
                InstrCnt <= InstrCnt + 1'b1;
            end else begin
                InstrCnt <= InstrCnt;
            end
        end
    end
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the 32-bit MIPS-style datapath.
- Splits each instruction into fetch, decode, execute, memory and writeback steps, so one ALU and one memory port are shared across cycles.
- Waits on a variable-latency memory ready handshake, with a timeout.
- Drives all datapath mux selects, write enables and the 4-bit ALUOp.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting on MemReady in any memory state before abort.
- CNT_W, 32: width of the performance counters (used only with the optional feature).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Opcode  input  6  Instr[31:26] from the instruction register.
- Funct  input  6  Instr[5:0] from the instruction register.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory access complete in this cycle.
- PCWrite  output  1  PC load enable.
- PCSrc  output  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target.
- IorD  output  1  memory address: 0 PC, 1 ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  write register: 1 rd, 0 rt.
- MemtoReg  output  1  write data: 1 memory, 0 ALUOut.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A operand: 0 PC, 1 register A.
- ALUSrcB  output  2  ALU B operand: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
- ALUOp  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 0101 sll, 0110 srl.
- shl_sel  output  1  read port 1 takes rt (shift instructions).
- shr_sel  output  1  ALU B operand takes shamt.
- Illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
- TimeoutErr  output  1  one-cycle pulse on a memory timeout.
- State  output  4  current state encoding, for debug.

Behaviour:
- Reset asserted (low):
  - State = FETCH (0).
  - Every control output forced to 0, including MemRead; outputs are gated by Reset.
  - Wait counter cleared.
  - Reset may be asserted mid-instruction; the FSM aborts immediately and no partial write occurs.
- Outputs are Moore, decoded from the state. Two exceptions depend on inputs: PCWrite/IRWrite in FETCH, and PCWrite in BEQ.
- Any output not listed for a state is 0.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00.
  - On MemReady: IRWrite=1 and PCWrite=1 in the same cycle, then go to DECODE.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw): MEMADR.
  - 000000 (R-type): RTYPE_EX.
  - 000100 (beq): BEQ.
  - 001000 (addi): ADDI_EX.
  - 000010 (j): JUMP.
  - Any other opcode: Illegal=1 for one cycle, back to FETCH.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, add. Next: MEMRD for lw, MEMWR for sw.
- MEMRD (3): MemRead=1, IorD=1. Hold until MemReady, then MEMWB.
- MEMWB (4): RegWrite=1, RegDst=0, MemtoReg=1. Next: FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Hold until MemReady, then FETCH.
- RTYPE_EX (6): ALUSrcA=1, ALUSrcB=00.
  - Funct to ALUOp: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 000010 srl.
  - For sll/srl: shl_sel=1 and shr_sel=1.
  - Unknown funct: Illegal pulse, no writeback, go to FETCH.
- RTYPE_WB (7): RegDst=1, RegWrite=1, MemtoReg=0. shl_sel/shr_sel held from RTYPE_EX. Next: FETCH.
- BEQ (8): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=Zero. Next: FETCH.
- ADDI_EX (9): ALUSrcA=1, ALUSrcB=10, add. Next: ADDI_WB.
- ADDI_WB (10): RegDst=0, RegWrite=1, MemtoReg=0. Next: FETCH.
- JUMP (11): PCSrc=10, PCWrite=1. Next: FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle MemReady=0.
  - On reaching MEM_TIMEOUT: TimeoutErr pulses, FSM goes to FETCH, no write enable is asserted.
  - A timeout in FETCH retries the same PC.
  - MemReady arriving in the same cycle as the limit wins; no timeout is flagged.
- Latency with MemReady=1 on first request:
  - lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- States 12-15 are unreachable; if entered, go to FETCH next cycle.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- Defined: adds outputs CycleCnt[CNT_W-1:0] and InstrCnt[CNT_W-1:0], both reset to 0.
  - CycleCnt increments every cycle out of reset.
  - InstrCnt increments on each return to FETCH from a completing state; illegal and timeout aborts are not counted.
  - Both counters wrap to 0 at overflow.
- Undefined: neither port nor the counter logic exists.

Test Plan:
- Reset low for 3 cycles, release, MemReady=1, opcode 000000 funct 100000 → states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7; ALUOp=0000 in state 6.
- lw (100011) with MemReady delayed 3 cycles in MEMRD → MemRead=1, IorD=1 held 4 cycles; MEMWB asserts RegWrite=1 and MemtoReg=1.
- beq with Zero=1, then again with Zero=0 → PCWrite=1 and PCSrc=01 in state 8 for the first, PCWrite=0 for the second.
- Opcode 111111 → Illegal pulses 1 cycle after DECODE; no RegWrite or MemWrite; State returns to 0.
- sw with MemReady held 0 and MEM_TIMEOUT=16 → TimeoutErr pulses after 16 wait cycles; MemWrite drops; State=0.
- Reset asserted during MEMWR → all outputs go 0 asynchronously; after release State=0 and fetch resumes.
